// File: rtl/mic1_datapath_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mic1_datapath_if : control/data bus bundle for the MIC-1 datapath  |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
interface mic1_datapath_if;
  logic [31:0] ROM_data;
  logic [31:0] RAM_data;
  logic [31:0] C;
  logic [15:0] MIR;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] MAR;
  logic [31:0] MDR;
  logic [31:0] PC;
  logic [31:0] MBR;

  // master drives control and memory data; slave is the datapath itself
  modport master (
    output ROM_data, RAM_data, C, MIR,
    input  A, B, MAR, MDR, PC, MBR
  );

  modport slave (
    input  ROM_data, RAM_data, C, MIR,
    output A, B, MAR, MDR, PC, MBR
  );
endinterface
`default_nettype wire

// File: rtl/mic1_datapath.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mic1_datapath : MIC-1 register file with B-bus mux and C-bus load  |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module mic1_datapath (
  input  wire               clock,
  input  wire               reset,
  mic1_datapath_if.slave    bus
);

  localparam logic [3:0] c_sel_mdr  = 4'd0;
  localparam logic [3:0] c_sel_pc   = 4'd1;
  localparam logic [3:0] c_sel_mbrs = 4'd2;
  localparam logic [3:0] c_sel_mbru = 4'd3;
  localparam logic [3:0] c_sel_sp   = 4'd4;
  localparam logic [3:0] c_sel_lv   = 4'd5;
  localparam logic [3:0] c_sel_cpp  = 4'd6;
  localparam logic [3:0] c_sel_tos  = 4'd7;
  localparam logic [3:0] c_sel_opc  = 4'd8;

  logic [31:0] r_h, r_opc, r_tos, r_cpp, r_lv, r_sp, r_pc, r_mdr, r_mar;
  logic [7:0]  r_mbr;
  logic [31:0] w_b;
  logic        w_unused;

  // reserved MIR bit and upper ROM bytes are deliberately ignored
  assign w_unused = ^{bus.MIR[0], bus.ROM_data[31:8]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_h   <= '0;
      r_opc <= '0;
      r_tos <= '0;
      r_cpp <= '0;
      r_lv  <= '0;
      r_sp  <= '0;
      r_pc  <= '0;
      r_mdr <= '0;
      r_mar <= '0;
      r_mbr <= '0;
    end else begin
      if (bus.MIR[11]) r_h   <= bus.C;
      if (bus.MIR[10]) r_opc <= bus.C;
      if (bus.MIR[9])  r_tos <= bus.C;
      if (bus.MIR[8])  r_cpp <= bus.C;
      if (bus.MIR[7])  r_lv  <= bus.C;
      if (bus.MIR[6])  r_sp  <= bus.C;
      if (bus.MIR[5])  r_pc  <= bus.C;
      if (bus.MIR[3])  r_mar <= bus.C;
      // a memory read takes precedence over a C-bus write to MDR
      if (bus.MIR[2])      r_mdr <= bus.RAM_data;
      else if (bus.MIR[4]) r_mdr <= bus.C;
      if (bus.MIR[1])  r_mbr <= bus.ROM_data[7:0];
    end
  end

  always_comb begin
    w_b = '0;
    case (bus.MIR[15:12])
      c_sel_mdr:  w_b = r_mdr;
      c_sel_pc:   w_b = r_pc;
      c_sel_mbrs: w_b = {{24{r_mbr[7]}}, r_mbr};
      c_sel_mbru: w_b = {24'd0, r_mbr};
      c_sel_sp:   w_b = r_sp;
      c_sel_lv:   w_b = r_lv;
      c_sel_cpp:  w_b = r_cpp;
      c_sel_tos:  w_b = r_tos;
      c_sel_opc:  w_b = r_opc;
      default:    w_b = '0;
    endcase
  end

  assign bus.A   = r_h;
  assign bus.B   = w_b;
  assign bus.MAR = r_mar;
  assign bus.MDR = r_mdr;
  assign bus.PC  = r_pc;
  assign bus.MBR = {24'd0, r_mbr};

endmodule
`default_nettype wire

// File: tb/tb_mic1_datapath.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mic1_datapath : directed self-checking bench for mic1_datapath  |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module tb_mic1_datapath;

  logic clock;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  mic1_datapath_if bus ();

  mic1_datapath dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // apply MIR/C, take one rising edge, land 1 time unit after it
  task automatic cycle(input logic [15:0] mir, input logic [31:0] c);
    bus.MIR = mir;
    bus.C   = c;
    @(posedge clock);
    #1;
    bus.MIR = 16'h0000;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.ROM_data = '0;
    bus.RAM_data = '0;
    bus.C        = '0;
    bus.MIR      = '0;
    #12;
    total_cnt++;
    if ({bus.A, bus.B, bus.MAR, bus.MDR, bus.PC, bus.MBR} !== 192'd0)
      $display("FAIL reset_outputs: got %h expected 0", {bus.A, bus.B, bus.MAR, bus.MDR, bus.PC, bus.MBR});
    else pass_cnt++;
    // loads requested while reset is held must not take effect
    bus.MIR = 16'h0FFE;
    bus.C   = 32'hFFFF_FFFF;
    bus.ROM_data = 32'h0000_00FF;
    bus.RAM_data = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    total_cnt++;
    if ({bus.A, bus.MAR, bus.MDR, bus.PC, bus.MBR} !== 160'd0)
      $display("FAIL reset_override: got %h expected 0", {bus.A, bus.MAR, bus.MDR, bus.PC, bus.MBR});
    else pass_cnt++;
    bus.MIR = '0;
    bus.C   = '0;
    bus.ROM_data = '0;
    bus.RAM_data = '0;
    reset = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    total_cnt++;
    if ({bus.A, bus.B, bus.MAR, bus.MDR, bus.PC, bus.MBR} !== 192'd0)
      $display("FAIL idle_after_reset: got %h expected 0", {bus.A, bus.B, bus.MAR, bus.MDR, bus.PC, bus.MBR});
    else pass_cnt++;
  endtask

  task automatic test_c_load();
    cycle(16'h0828, 32'h1234_5678);
    total_cnt++;
    if (bus.A !== 32'h1234_5678) $display("FAIL c_load_A: got %h expected %h", bus.A, 32'h1234_5678);
    else pass_cnt++;
    total_cnt++;
    if (bus.PC !== 32'h1234_5678) $display("FAIL c_load_PC: got %h expected %h", bus.PC, 32'h1234_5678);
    else pass_cnt++;
    total_cnt++;
    if (bus.MAR !== 32'h1234_5678) $display("FAIL c_load_MAR: got %h expected %h", bus.MAR, 32'h1234_5678);
    else pass_cnt++;
    total_cnt++;
    if (bus.MDR !== 32'h0) $display("FAIL c_load_MDR: got %h expected %h", bus.MDR, 32'h0);
    else pass_cnt++;
    bus.MIR = 16'h1000; #1;
    total_cnt++;
    if (bus.B !== 32'h1234_5678) $display("FAIL bsel_pc: got %h expected %h", bus.B, 32'h1234_5678);
    else pass_cnt++;
    bus.MIR = 16'h0000;
  endtask

  task automatic test_read_priority();
    bus.RAM_data = 32'hDEAD_BEEF;
    cycle(16'h0014, 32'h0000_0001);
    total_cnt++;
    if (bus.MDR !== 32'hDEAD_BEEF) $display("FAIL read_wins_MDR: got %h expected %h", bus.MDR, 32'hDEAD_BEEF);
    else pass_cnt++;
    total_cnt++;
    if (bus.B !== 32'hDEAD_BEEF) $display("FAIL bsel_mdr: got %h expected %h", bus.B, 32'hDEAD_BEEF);
    else pass_cnt++;
    cycle(16'h0010, 32'h0000_0001);
    total_cnt++;
    if (bus.MDR !== 32'h0000_0001) $display("FAIL c_load_MDR_only: got %h expected %h", bus.MDR, 32'h1);
    else pass_cnt++;
  endtask

  task automatic test_fetch();
    bus.ROM_data = 32'hAABB_CC85;
    cycle(16'h0002, 32'h0);
    total_cnt++;
    if (bus.MBR !== 32'h0000_0085) $display("FAIL fetch_MBR: got %h expected %h", bus.MBR, 32'h85);
    else pass_cnt++;
    bus.MIR = 16'h2000; #1;
    total_cnt++;
    if (bus.B !== 32'hFFFF_FF85) $display("FAIL bsel_mbr_sext: got %h expected %h", bus.B, 32'hFFFF_FF85);
    else pass_cnt++;
    bus.MIR = 16'h3000; #1;
    total_cnt++;
    if (bus.B !== 32'h0000_0085) $display("FAIL bsel_mbr_zext: got %h expected %h", bus.B, 32'h85);
    else pass_cnt++;
    bus.ROM_data = 32'hFFFF_FF7F;
    cycle(16'h0002, 32'h0);
    bus.MIR = 16'h2000; #1;
    total_cnt++;
    if (bus.B !== 32'h0000_007F) $display("FAIL bsel_mbr_sext_pos: got %h expected %h", bus.B, 32'h7F);
    else pass_cnt++;
    bus.MIR = 16'h0000;
  endtask

  task automatic test_b_select();
    cycle(16'h0040, 32'h0000_0010);
    cycle(16'h0080, 32'h0000_0020);
    cycle(16'h0100, 32'h0000_0030);
    cycle(16'h0200, 32'h0000_0040);
    cycle(16'h0400, 32'h0000_0050);
    bus.MIR = 16'h4000; #1;
    total_cnt++;
    if (bus.B !== 32'h10) $display("FAIL bsel_sp: got %h expected %h", bus.B, 32'h10);
    else pass_cnt++;
    bus.MIR = 16'h5000; #1;
    total_cnt++;
    if (bus.B !== 32'h20) $display("FAIL bsel_lv: got %h expected %h", bus.B, 32'h20);
    else pass_cnt++;
    bus.MIR = 16'h6000; #1;
    total_cnt++;
    if (bus.B !== 32'h30) $display("FAIL bsel_cpp: got %h expected %h", bus.B, 32'h30);
    else pass_cnt++;
    bus.MIR = 16'h7000; #1;
    total_cnt++;
    if (bus.B !== 32'h40) $display("FAIL bsel_tos: got %h expected %h", bus.B, 32'h40);
    else pass_cnt++;
    bus.MIR = 16'h8000; #1;
    total_cnt++;
    if (bus.B !== 32'h50) $display("FAIL bsel_opc: got %h expected %h", bus.B, 32'h50);
    else pass_cnt++;
    for (int s = 9; s < 16; s++) begin
      bus.MIR = 16'(s) << 12; #1;
      total_cnt++;
      if (bus.B !== 32'h0) $display("FAIL bsel_unused_%0d: got %h expected %h", s, bus.B, 32'h0);
      else pass_cnt++;
    end
    bus.MIR = 16'h0000; #1;
    total_cnt++;
    if (bus.A !== 32'h1234_5678) $display("FAIL hold_H: got %h expected %h", bus.A, 32'h1234_5678);
    else pass_cnt++;
  endtask

  task automatic test_noop();
    bus.RAM_data = 32'hCAFE_BABE;
    bus.ROM_data = 32'h0000_0011;
    cycle(16'h0001, 32'hFFFF_FFFF);
    cycle(16'h0000, 32'hFFFF_FFFF);
    total_cnt++;
    if ({bus.A, bus.MAR, bus.MDR, bus.PC, bus.MBR} !==
        {32'h1234_5678, 32'h1234_5678, 32'h1, 32'h1234_5678, 32'h7F})
      $display("FAIL noop_hold: got %h expected %h", {bus.A, bus.MAR, bus.MDR, bus.PC, bus.MBR},
               {32'h1234_5678, 32'h1234_5678, 32'h1, 32'h1234_5678, 32'h7F});
    else pass_cnt++;
    total_cnt++;
    if (bus.B !== 32'h1) $display("FAIL noop_B: got %h expected %h", bus.B, 32'h1);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bus.MIR = 16'h1000;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({bus.A, bus.B, bus.MAR, bus.MDR, bus.PC, bus.MBR} !== 192'd0)
      $display("FAIL async_reset: got %h expected 0", {bus.A, bus.B, bus.MAR, bus.MDR, bus.PC, bus.MBR});
    else pass_cnt++;
    bus.MIR = 16'h0000;
    @(posedge clock); #1;
    reset = 1'b0;
    cycle(16'h0800, 32'h0000_00AA);
    total_cnt++;
    if (bus.A !== 32'hAA) $display("FAIL first_load_after_reset: got %h expected %h", bus.A, 32'hAA);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_c_load();
    test_read_priority();
    test_fetch();
    test_b_select();
    test_noop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mic1_datapath.md
MIC1_DATAPATH -- requirements
Module: mic1_datapath

Interface
REQ-001: Parameters: none; all widths fixed as listed below.
REQ-002: clock  input  1  single clock; all register updates on rising edge.
REQ-003: reset  input  1  asynchronous, active-high; clears all internal registers.
REQ-004: ROM_data  input  32  instruction-store read data; low byte is the fetched opcode byte.
REQ-005: RAM_data  input  32  data-memory read word.
REQ-006: C  input  32  C-bus value from the external ALU/shifter, written to the selected registers.
REQ-007: MIR  input  16  microinstruction control word.
REQ-008: A  output  32  A-bus; always equals register H.
REQ-009: B  output  32  B-bus; the register selected by MIR[15:12].
REQ-010: MAR  output  32  memory address register.
REQ-011: MDR  output  32  memory data register.
REQ-012: PC  output  32  program counter.
REQ-013: MBR  output  32  memory byte register, zero-extended to 32 bits.

Function
REQ-014: Internal 32-bit registers SHALL be H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR; MBR SHALL be 8 bits.
REQ-015: MIR fields SHALL be: [15:12] B select; [11:3] C enables; [2] READ; [1] FETCH; [0] reserved, ignored.
REQ-016: C enables SHALL map MIR[11]=H, [10]=OPC, [9]=TOS, [8]=CPP, [7]=LV, [6]=SP, [5]=PC, [4]=MDR, [3]=MAR.
REQ-017: On each rising edge, every register whose enable bit is 1 SHALL load C; any number may load simultaneously.
REQ-018: Registers whose enable bit is 0 SHALL hold their value.
REQ-019: B select SHALL map 0=MDR, 1=PC, 2=MBR sign-extended from bit 7, 3=MBR zero-extended, 4=SP, 5=LV, 6=CPP, 7=TOS, 8=OPC; values 9-15 SHALL drive B=0.
REQ-020: A and B SHALL be combinational from current register state, with no clock latency.
REQ-021: READ=1 SHALL load MDR with RAM_data on the same rising edge.
REQ-022: If READ=1 and MIR[4]=1 in the same cycle, RAM_data SHALL win.
REQ-023: FETCH=1 SHALL load MBR with ROM_data[7:0] on the same rising edge; ROM_data[31:8] SHALL be ignored.
REQ-024: MBR output port SHALL be {24'b0, MBR}.
REQ-025: MAR, MDR and PC output ports SHALL reflect the registers directly.
REQ-026: No arithmetic SHALL be performed inside the block; the C value is written unmodified.
REQ-027: MIR=0 SHALL be a pure no-op cycle: no register changes, B=MDR.

Reset
REQ-028: While reset=1, all registers including MBR SHALL be 0 immediately, without waiting for a clock edge.
REQ-029: With reset=1, A, B, MAR, MDR, PC and MBR SHALL all read 0.
REQ-030: Reset SHALL override any register load in the same cycle.
REQ-031: The first load SHALL occur at the first rising edge after reset deasserts.

Verification
REQ-032: All inputs 0, reset pulse, then two clocks -> every output stays 0.
REQ-033: C=0x12345678, MIR enables H|PC|MAR, one edge -> A=0x12345678, PC=0x12345678, MAR=0x12345678, MDR=0.
REQ-034: RAM_data=0xDEADBEEF, READ=1, MIR[4]=1, C=0x1 -> MDR=0xDEADBEEF; B (select 0) = 0xDEADBEEF.
REQ-035: ROM_data=0xAABBCC85, FETCH=1 -> MBR=0x00000085; select 2 gives B=0xFFFFFF85; select 3 gives B=0x00000085.
REQ-036: Load SP=0x10, then B select 4 -> B=0x10; select 12 -> B=0.
REQ-037: Assert reset mid-run with registers nonzero -> all outputs 0 before the next clock edge.
